// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state ring counter, control-word decoder
// and the HLT latch that freezes the machine until CLR.
module sap1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic       HLT,
  output logic       instr_done
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [5:0] t_next;
  logic       halted;
  logic       halted_next;
  logic       active;

  // State register: CLR always lands on T1 with the halt latch cleared.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halted_next;
    end
  end

  // Ring advance; a HLT opcode at the end of T4 freezes the counter in T5.
  always_comb begin
    t_next      = t_state;
    halted_next = halted;
    if (!halted) begin
      case (t_state)
        T1: t_next = T2;
        T2: t_next = T3;
        T3: t_next = T4;
        T4: begin
          t_next = T5;
          if (opcode == OP_HLT) halted_next = 1'b1;
        end
        T5: t_next = T6;
        T6: t_next = T1;
        default: t_next = T1;
      endcase
    end
  end

  assign active = !CLR && !halted;

  // Control-word decode; opcode is consulted only in the execute states.
  always_comb begin
    CP = 1'b0;
    EP = 1'b0;
    LM = 1'b0;
    CE = 1'b0;
    LI = 1'b0;
    EI = 1'b0;
    LA = 1'b0;
    EA = 1'b0;
    SU = 1'b0;
    EU = 1'b0;
    LB = 1'b0;
    LO = 1'b0;
    if (active) begin
      case (t_state)
        T1: begin
          EP = 1'b1;
          LM = 1'b1;
        end
        T2: CP = 1'b1;
        T3: begin
          CE = 1'b1;
          LI = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              EI = 1'b1;
              LM = 1'b1;
            end
            OP_OUT: begin
              EA = 1'b1;
              LO = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              CE = 1'b1;
              LA = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              CE = 1'b1;
              LB = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              LA = 1'b1;
              EU = 1'b1;
            end
            OP_SUB: begin
              LA = 1'b1;
              EU = 1'b1;
              SU = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign HLT        = halted && !CLR;
  assign instr_done = active && (t_state == T6);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Scoreboard bench for the SAP-1 controller-sequencer against an
// instruction-level reference model of the fetch/execute table.
module tb_sap1_controller_sequencer;

  logic       CLK;
  logic       CLR;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT, instr_done;

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .t_state(t_state),
    .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI), .LA(LA),
    .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO), .HLT(HLT),
    .instr_done(instr_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control word bit masks, order {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}.
  localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200;
  localparam logic [11:0] M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040;
  localparam logic [11:0] M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008;
  localparam logic [11:0] M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

  typedef struct packed {
    logic        chk_t;
    logic [5:0]  t;
    logic [11:0] ctrl;
    logic        hlt;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position within the instruction (0 = T1) and halt flag.
  int m_step   = 0;
  bit m_halted = 1'b0;
  bit m_known  = 1'b0;

  function automatic logic [11:0] ref_ctrl(input int step, input logic [3:0] op);
    logic [11:0] w;
    w = '0;
    case (step)
      0: w = M_EP | M_LM;
      1: w = M_CP;
      2: w = M_CE | M_LI;
      3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = M_EI | M_LM;
         else if (op == 4'hE) w = M_EA | M_LO;
      4: if (op == 4'h0) w = M_CE | M_LA;
         else if (op == 4'h1 || op == 4'h2) w = M_CE | M_LB;
      5: if (op == 4'h1) w = M_LA | M_EU;
         else if (op == 4'h2) w = M_LA | M_EU | M_SU;
      default: w = '0;
    endcase
    return w;
  endfunction

  // One clock of stimulus: drive, predict this cycle's outputs, advance model.
  task automatic tick(input logic clr, input logic [3:0] op);
    exp_t e;
    @(posedge CLK);
    #1;
    CLR    = clr;
    opcode = op;
    e.chk_t = m_known;
    e.t     = 6'(1 << m_step);
    e.ctrl  = (clr || m_halted) ? 12'h000 : ref_ctrl(m_step, op);
    e.hlt   = m_halted && !clr;
    e.done  = !clr && !m_halted && (m_step == 5);
    sb.push_back(e);
    if (clr) begin
      m_step   = 0;
      m_halted = 1'b0;
      m_known  = 1'b1;
    end else if (!m_halted) begin
      if (m_step == 3 && op == 4'hF) begin
        m_halted = 1'b1;
        m_step   = 4;
      end else begin
        m_step = (m_step + 1) % 6;
      end
    end
  endtask

  // Run one instruction from T1; opcode is random noise during fetch.
  task automatic run_instr(input logic [3:0] op, input int clr_at);
    logic c;
    for (int k = 0; k < 6; k++) begin
      if (m_halted) break;
      c = (k == clr_at);
      tick(c, (k < 3) ? 4'($urandom) : op);
      if (c) break;
    end
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_t) check("t_state", 12'(t_state), 12'(e.t));
      check("ctrl", {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO}, e.ctrl);
      check("HLT", 12'(HLT), 12'(e.hlt));
      check("instr_done", 12'(instr_done), 12'(e.done));
      vectors++;
      if ($countones({EP, CE, EI, EA, EU}) > 1 || (SU && !EU)) begin
        miscompares++;
        $display("FAIL protocol at %0t: drivers %b SU %b EU %b", $time,
                 {EP, CE, EI, EA, EU}, SU, EU);
      end
    end
  end

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'hE;
      4: return 4'hF;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    int budget;
    logic [3:0] op;
    CLR    = 1'b1;
    opcode = 4'hF;
    repeat (3) tick(1'b1, 4'hF);
    run_instr(4'h1, -1);
    run_instr(4'h2, -1);
    run_instr(4'h0, -1);
    run_instr(4'hE, -1);
    run_instr(4'h5, -1);
    run_instr(4'hF, -1);
    repeat (20) tick(1'b0, 4'($urandom));
    tick(1'b1, 4'hF);
    run_instr(4'h2, 4);
    run_instr(4'h1, -1);
    // Randomized instruction stream with occasional resets and halts.
    for (int n = 0; n < 120; n++) begin
      op = pick_op();
      run_instr(op, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1);
      if (m_halted) begin
        repeat ($urandom_range(2, 12)) tick(1'b0, 4'($urandom));
        tick(1'b1, 4'($urandom));
      end
    end
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
